pulse_stretch: RTL and testbench

- Output-side counterpart to the input debouncer: turns short, machine-speed events into long, human-visible pulses.
- Typical uses are LED flashes and buzzer chirps in the reaction game.
- Each rising edge on trig_in yields one output pulse exactly HOLD_CNT cycles long, followed by a forced low gap of GAP_CNT cycles.
- Events that arrive while a pulse or gap is in progress are queued in a saturating pending counter and replayed in order.

---
 rtl/pulse_pkg.sv | 26 ++
 rtl/edge_rise.sv | 31 +++
 rtl/pulse_stretch.sv | 133 +++++++++++++
 tb/tb_pulse_stretch.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_pkg.sv
// -----------------------------------------------------------------------------
// pulse_pkg
// Shared definitions for the pulse stretcher and its helpers.
//   state_t   : FSM encoding (IDLE / HOLD / GAP)
//   PEND_W    : width of the pending-event counter
//   cnt_width : phase-counter width able to count 0..max(hold,gap)-1
// -----------------------------------------------------------------------------
package pulse_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam int PEND_W = 4;

    // A phase of N cycles needs clog2(N) bits to count 0..N-1. The result is
    // clamped to 1 so a 1-cycle hold and a 1-cycle gap still get a real counter.
    function automatic int cnt_width(input int hold_cnt, input int gap_cnt);
        int longest;
        longest = (hold_cnt > gap_cnt) ? hold_cnt : gap_cnt;
        return (longest > 1) ? $clog2(longest) : 1;
    endfunction

endpackage

// File: rtl/edge_rise.sv
// -----------------------------------------------------------------------------
// edge_rise
// Registered 0->1 detector. rise is high for the cycle in which d is 1 and was
// 0 at the previous clock edge; a level held high yields a single event.
//   clk   : clock, posedge
//   rst_n : asynchronous active-low reset (previous sample forced to 0)
//   d     : level input, synchronous to clk
//   rise  : one-cycle event on a 0->1 transition of d
// -----------------------------------------------------------------------------
module edge_rise (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise
);

    logic d_prev;

    // NOTE: sequential state is always written with <= so every flop samples
    // the pre-edge values, independent of statement or process order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_prev <= 1'b0;
        end else begin
            d_prev <= d;
        end
    end

    assign rise = d & ~d_prev;

endmodule

// File: rtl/pulse_stretch.sv
// -----------------------------------------------------------------------------
// pulse_stretch
// Turns single-cycle events into HOLD_CNT-cycle high pulses separated by at
// least GAP_CNT low cycles. Events arriving while a pulse or gap is running are
// counted (up to PEND_MAX) and replayed back-to-back; excess events are dropped
// and flagged in a sticky overflow bit.
//   clk      : clock, posedge
//   rst_n    : asynchronous active-low reset
//   trig_in  : event request; each 0->1 transition is one event
//   clr_ovf  : synchronous clear of overflow (a same-cycle drop wins)
//   sig_out  : stretched pulse, registered
//   busy     : high while in HOLD or GAP, registered
//   pend_cnt : queued events not yet issued
//   overflow : sticky, set when an event is dropped
// -----------------------------------------------------------------------------
module pulse_stretch
    import pulse_pkg::*;
#(
    parameter logic [15:0] HOLD_CNT = 16'd50000,
    parameter logic [15:0] GAP_CNT  = 16'd10000,
    parameter int          PEND_MAX = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              trig_in,
    input  logic              clr_ovf,
    output logic              sig_out,
    output logic              busy,
    output logic [PEND_W-1:0] pend_cnt,
    output logic              overflow
);

    localparam int                CNT_W     = cnt_width(int'(HOLD_CNT), int'(GAP_CNT));
    localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(int'(HOLD_CNT) - 1);
    localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(int'(GAP_CNT) - 1);
    localparam logic [PEND_W-1:0] PEND_FULL = PEND_W'(PEND_MAX);
    localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    state_t             state;
    logic [CNT_W-1:0]   count;
    logic               evt;
    logic               gap_last;
    logic               queue_evt;
    logic               drop;

    edge_rise u_edge_rise (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (trig_in),
        .rise  (evt)
    );

    // The terminal GAP cycle is excluded from queueing: there an event either
    // starts the next pulse directly or cancels against the replayed one.
    assign gap_last  = (state == GAP) && (count == GAP_LAST);
    assign queue_evt = evt && ((state == HOLD) || ((state == GAP) && !gap_last));
    assign drop      = queue_evt && (pend_cnt == PEND_FULL);

    // Reset is asynchronous, so a pulse in progress is cut the moment rst_n falls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            count    <= '0;
            sig_out  <= 1'b0;
            busy     <= 1'b0;
            pend_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end

            if (queue_evt && !drop) begin
                pend_cnt <= pend_cnt + PEND_ONE;
            end

            case (state)
                IDLE: begin
                    if (evt) begin
                        state   <= HOLD;
                        count   <= '0;
                        sig_out <= 1'b1;
                        busy    <= 1'b1;
                    end
                end

                HOLD: begin
                    if (count == HOLD_LAST) begin
                        state   <= GAP;
                        count   <= '0;
                        sig_out <= 1'b0;
                    end else begin
                        count <= count + CNT_ONE;
                    end
                end

                GAP: begin
                    if (gap_last) begin
                        count <= '0;
                        if (pend_cnt != '0) begin
                            // Replay a queued event; a simultaneous new event
                            // takes its slot, leaving the count unchanged.
                            state   <= HOLD;
                            sig_out <= 1'b1;
                            if (!evt) begin
                                pend_cnt <= pend_cnt - PEND_ONE;
                            end
                        end else if (evt) begin
                            state   <= HOLD;
                            sig_out <= 1'b1;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        count <= count + CNT_ONE;
                    end
                end

                default: begin
                    state   <= IDLE;
                    count   <= '0;
                    sig_out <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_stretch.sv
// -----------------------------------------------------------------------------
// tb_pulse_stretch
// Small-parameter DUT (HOLD=4, GAP=2, PEND_MAX=2) driven by directed patterns
// and randomized trig/clr/reset traffic, compared every cycle against a
// schedule-based model: each accepted event owns a start edge, pulses are
// served in order, each occupies HOLD+GAP edges. A default-parameter instance
// checks the full 50000/10000 timing.
// -----------------------------------------------------------------------------
module tb_pulse_stretch;

    localparam int H  = 4;
    localparam int G  = 2;
    localparam int PM = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       trig_in = 1'b0;
    logic       clr_ovf = 1'b0;
    logic       trig_def = 1'b0;
    logic       sig_out, busy, overflow;
    logic [3:0] pend_cnt;
    logic       sig_def, busy_def, ovf_def;
    logic [3:0] pend_def;

    always #5 clk = ~clk;

    pulse_stretch #(
        .HOLD_CNT (16'd4),
        .GAP_CNT  (16'd2),
        .PEND_MAX (2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .trig_in  (trig_in),
        .clr_ovf  (clr_ovf),
        .sig_out  (sig_out),
        .busy     (busy),
        .pend_cnt (pend_cnt),
        .overflow (overflow)
    );

    pulse_stretch dut_def (
        .clk      (clk),
        .rst_n    (rst_n),
        .trig_in  (trig_def),
        .clr_ovf  (1'b0),
        .sig_out  (sig_def),
        .busy     (busy_def),
        .pend_cnt (pend_def),
        .overflow (ovf_def)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int   cyc = 0;          // count of clock edges seen out of reset
    int   starts[$];        // start edge of every accepted pulse (recent ones)
    logic m_prev = 1'b0;
    logic m_ovf  = 1'b0;
    logic ps_sig = 1'b0;    // previous sampled sig_out for the width monitor
    int   hi_run = 0;
    int   lo_run = 0;
    bit   seen_pulse = 0;

    function automatic int pending_after(input int e);
        int n = 0;
        foreach (starts[i]) if (starts[i] > e) n++;
        return n;
    endfunction

    function automatic logic exp_sig(input int e);
        foreach (starts[i]) if (starts[i] <= e && e < starts[i] + H) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic exp_busy(input int e);
        foreach (starts[i]) if (starts[i] <= e && e < starts[i] + H + G) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        starts.delete();
        m_prev     = 1'b0;
        m_ovf      = 1'b0;
        ps_sig     = 1'b0;
        hi_run     = 0;
        lo_run     = 0;
        seen_pulse = 0;
    endtask

    always @(posedge clk) begin : compare
        logic evt;
        logic dropped;
        int   ns;
        if (rst_n) begin
            cyc++;
            evt     = trig_in && !m_prev;
            m_prev  = trig_in;
            dropped = 1'b0;
            if (evt) begin
                if (pending_after(cyc) == PM) begin
                    dropped = 1'b1;
                end else begin
                    ns = cyc;
                    if (starts.size() > 0 && starts[$] + H + G > cyc) ns = starts[$] + H + G;
                    starts.push_back(ns);
                end
            end
            if (dropped) m_ovf = 1'b1;
            else if (clr_ovf) m_ovf = 1'b0;
            while (starts.size() > 1 && starts[0] + H + G < cyc) void'(starts.pop_front());

            #1;
            if (rst_n) begin
                check("m_sig",  32'(sig_out),  32'(exp_sig(cyc)));
                check("m_busy", 32'(busy),     32'(exp_busy(cyc)));
                check("m_pend", 32'(pend_cnt), 32'(pending_after(cyc)));
                check("m_ovf",  32'(overflow), 32'(m_ovf));
                // Model-independent shape checks on the observed waveform.
                if (sig_out && !ps_sig) begin
                    if (seen_pulse) check("gap_min", 32'(lo_run >= G), 32'd1);
                    hi_run = 1;
                end else if (sig_out) begin
                    hi_run++;
                end else if (ps_sig) begin
                    check("hold_len", 32'(hi_run), 32'(H));
                    seen_pulse = 1;
                    lo_run = 1;
                end else begin
                    lo_run++;
                end
                ps_sig = sig_out;
            end
        end
    end

    // ---------------- directed helpers ----------------
    logic rec_sig[32], rec_busy[32], rec_ovf[32];
    logic [3:0] rec_pend[32];

    // Bit i of tp/cp is the trig_in/clr_ovf level seen by edge i; rec_* hold
    // the outputs just after edge i.
    task automatic run_pattern(input logic [31:0] tp, input logic [31:0] cp, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            trig_in = tp[i];
            clr_ovf = cp[i];
            @(posedge clk);
            #2;
            rec_sig[i]  = sig_out;
            rec_busy[i] = busy;
            rec_pend[i] = pend_cnt;
            rec_ovf[i]  = overflow;
        end
        trig_in = 1'b0;
        clr_ovf = 1'b0;
    endtask

    function automatic int rises(input int n);
        int r = 0;
        for (int i = 0; i < n; i++) if (rec_sig[i] && (i == 0 || !rec_sig[i-1])) r++;
        return r;
    endfunction

    task automatic async_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_sig",  32'(sig_out),  32'd0);
        check("rst_busy", 32'(busy),     32'd0);
        check("rst_pend", 32'(pend_cnt), 32'd0);
        check("rst_ovf",  32'(overflow), 32'd0);
        @(negedge clk);
        trig_in = 1'b0;
        clr_ovf = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin : stim
        int hi;
        int p;
        model_reset();
        repeat (2) @(negedge clk);
        check("init_sig",  32'(sig_out),  32'd0);
        check("init_busy", 32'(busy),     32'd0);
        check("init_pend", 32'(pend_cnt), 32'd0);
        check("init_ovf",  32'(overflow), 32'd0);
        rst_n = 1'b1;

        // 1: single event, level held 20 cycles
        run_pattern(32'h000F_FFFF, 32'h0, 30);
        check("t1_sig0",  32'(rec_sig[0]),  32'd1);
        check("t1_sig3",  32'(rec_sig[3]),  32'd1);
        check("t1_sig4",  32'(rec_sig[4]),  32'd0);
        check("t1_busy5", 32'(rec_busy[5]), 32'd1);
        check("t1_busy6", 32'(rec_busy[6]), 32'd0);
        check("t1_rises", 32'(rises(30)),   32'd1);

        // 2: second event during the first HOLD
        run_pattern(32'h5, 32'h0, 30);
        check("t2_pend2",  32'(rec_pend[2]),  32'd1);
        check("t2_sig4",   32'(rec_sig[4]),   32'd0);
        check("t2_sig6",   32'(rec_sig[6]),   32'd1);
        check("t2_pend5",  32'(rec_pend[5]),  32'd1);
        check("t2_pend6",  32'(rec_pend[6]),  32'd0);
        check("t2_sig10",  32'(rec_sig[10]),  32'd0);
        check("t2_busy12", 32'(rec_busy[12]), 32'd0);

        // 3: events at 0,2,4,8,10; the one at 10 overflows while clr_ovf is high
        run_pattern(32'h515, 32'h400, 32);
        check("t3_pend2",  32'(rec_pend[2]),  32'd1);
        check("t3_pend4",  32'(rec_pend[4]),  32'd2);
        check("t3_pend6",  32'(rec_pend[6]),  32'd1);
        check("t3_pend8",  32'(rec_pend[8]),  32'd2);
        check("t3_pend10", 32'(rec_pend[10]), 32'd2);
        check("t3_ovf9",   32'(rec_ovf[9]),   32'd0);
        check("t3_ovf10",  32'(rec_ovf[10]),  32'd1);
        check("t3_rises",  32'(rises(32)),    32'd4);
        check("t3_busy23", 32'(rec_busy[23]), 32'd1);
        check("t3_busy24", 32'(rec_busy[24]), 32'd0);
        run_pattern(32'h0, 32'h1, 1);
        check("t3_clr",    32'(rec_ovf[0]),   32'd0);

        // 4: event exactly on the terminal GAP edge with nothing queued
        run_pattern(32'h41, 32'h0, 20);
        check("t4_sig5",   32'(rec_sig[5]),   32'd0);
        check("t4_sig6",   32'(rec_sig[6]),   32'd1);
        check("t4_pend6",  32'(rec_pend[6]),  32'd0);
        hi = 0;
        for (int i = 0; i < 12; i++) hi += int'(rec_busy[i]);
        check("t4_busy_cont", 32'(hi), 32'd12);
        check("t4_busy12", 32'(rec_busy[12]), 32'd0);

        // 5: reset during HOLD, then a held level gives one pulse
        run_pattern(32'h3, 32'h0, 2);
        async_reset();
        run_pattern(32'h0000_03FF, 32'h0, 20);
        check("t5_rises", 32'(rises(20)), 32'd1);

        // Randomized traffic with varying event density and rare resets
        for (int seg = 0; seg < 5; seg++) begin
            p = (seg == 0) ? 2 : (seg == 1) ? 3 : (seg == 2) ? 6 : (seg == 3) ? 12 : 4;
            for (int i = 0; i < 300; i++) begin
                @(negedge clk);
                if ($urandom_range(0, 399) == 0) begin
                    async_reset();
                end else begin
                    if ($urandom_range(0, p - 1) == 0) trig_in = ~trig_in;
                    clr_ovf = ($urandom_range(0, 15) == 0);
                end
            end
        end
        @(negedge clk);
        trig_in = 1'b0;
        clr_ovf = 1'b0;
        repeat (40) @(negedge clk);

        // 6: default parameters, one event
        trig_def = 1'b1;
        hi = 0;
        for (int i = 0; i <= 60000; i++) begin
            @(posedge clk);
            #2;
            hi += int'(sig_def);
            if (i == 0)     check("t6_sig_first",   32'(sig_def),  32'd1);
            if (i == 49999) check("t6_sig_last",    32'(sig_def),  32'd1);
            if (i == 50000) check("t6_sig_off",     32'(sig_def),  32'd0);
            if (i == 59999) check("t6_busy_last",   32'(busy_def), 32'd1);
            if (i == 60000) check("t6_busy_off",    32'(busy_def), 32'd0);
        end
        check("t6_high_cycles", 32'(hi), 32'd50000);
        check("t6_pend", 32'(pend_def), 32'd0);
        check("t6_ovf",  32'(ovf_def),  32'd0);
        trig_def = 1'b0;

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
